// File: rtl/reg_forward_unit_pkg.sv
// Shared bus defaults, zero-register index and operand-source encoding for the
// operand-forwarding unit.
package reg_forward_unit_pkg;

  localparam int unsigned DATA_BUS     = 32;
  localparam int unsigned REG_ADDR_BUS = 5;
  localparam int unsigned ZERO_REG_IDX = 0;

  typedef enum logic [2:0] {
    SRC_OFF  = 3'd0,
    SRC_ZERO = 3'd1,
    SRC_FWD  = 3'd2,
    SRC_WB   = 3'd3,
    SRC_HOLD = 3'd4,
    SRC_REG  = 3'd5
  } src_e;

  // Only values that may disappear from the pipeline while ID stalls are worth holding.
  function automatic logic src_holdable(input src_e src);
    case (src)
      SRC_FWD, SRC_WB, SRC_HOLD: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_forward_unit_fwd_port_mux.sv
// One read port: priority operand select (zero, forwarding stages, WB, hold, regfile)
// plus the hold register that keeps a resolved operand alive across ID stalls.
module fwd_port_mux
  import reg_forward_unit_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned DATA_WIDTH = DATA_BUS,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_BUS,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_stall,
  input  logic                             read_en,
  input  logic [ADDR_WIDTH-1:0]            read_addr,
  input  logic [DATA_WIDTH-1:0]            reg_data,
  input  logic [FWD_STAGES-1:0]            fwd_we,
  input  logic [FWD_STAGES*ADDR_WIDTH-1:0] fwd_addr,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_data,
  input  logic [FWD_STAGES-1:0]            fwd_load,
  input  logic                             wb_we,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             load_related,
  output logic                             hold_valid
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG_IDX);

  logic [FWD_STAGES-1:0] fwd_hit_s;
  logic [DATA_WIDTH-1:0] fwd_sel_data_s;
  logic                  fwd_sel_load_s;
  src_e                  src_s;

  logic                  hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

  // Walk from oldest to youngest so the youngest matching stage is the one left selected.
  always_comb begin
    fwd_hit_s      = '0;
    fwd_sel_data_s = '0;
    fwd_sel_load_s = 1'b0;
    for (int s = FWD_STAGES - 1; s >= 0; s--) begin
      fwd_hit_s[s]   = fwd_we[s] && (fwd_addr[s*ADDR_WIDTH +: ADDR_WIDTH] == read_addr);
      fwd_sel_data_s = fwd_hit_s[s] ? fwd_data[s*DATA_WIDTH +: DATA_WIDTH] : fwd_sel_data_s;
      fwd_sel_load_s = fwd_hit_s[s] ? fwd_load[s] : fwd_sel_load_s;
    end
  end

  // Operand priority select.
  always_comb begin
    src_s        = SRC_REG;
    read_data    = reg_data;
    load_related = 1'b0;
    if (!read_en) begin
      src_s     = SRC_OFF;
      read_data = '0;
    end else if (ZERO_REG && (read_addr == ZERO_ADDR)) begin
      src_s     = SRC_ZERO;
      read_data = '0;
    end else if (|fwd_hit_s) begin
      src_s        = SRC_FWD;
      load_related = fwd_sel_load_s;
      read_data    = fwd_sel_load_s ? '0 : fwd_sel_data_s;
    end else if (wb_we && (wb_addr == read_addr)) begin
      src_s     = SRC_WB;
      read_data = wb_data;
    end else if (hold_valid_q && (hold_addr_q == read_addr)) begin
      src_s     = SRC_HOLD;
      read_data = hold_data_q;
    end else begin
      src_s     = SRC_REG;
      read_data = reg_data;
    end
  end

  // Hold next state: clear wins over capture; a load-blocked port never captures.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    if (!id_stall || !read_en) begin
      hold_valid_d = 1'b0;
    end else if (!load_related && src_holdable(src_s)) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = read_addr;
      hold_data_d  = read_data;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Hold register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign hold_valid = hold_valid_q;

endmodule

// File: rtl/reg_forward_unit.sv
// Operand forwarding and load-use interlock: one fwd_port_mux per read port, the
// combined stall request and a saturating load-use stall counter.
module reg_forward_unit
  import reg_forward_unit_pkg::*;
#(
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned DATA_WIDTH = DATA_BUS,
  parameter int unsigned ADDR_WIDTH = REG_ADDR_BUS,
  parameter bit          ZERO_REG   = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_stall,
  input  logic [READ_PORTS-1:0]            read_en,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  input  logic [READ_PORTS*DATA_WIDTH-1:0] reg_data,
  input  logic [FWD_STAGES-1:0]            fwd_we,
  input  logic [FWD_STAGES*ADDR_WIDTH-1:0] fwd_addr,
  input  logic [FWD_STAGES*DATA_WIDTH-1:0] fwd_data,
  input  logic [FWD_STAGES-1:0]            fwd_load,
  input  logic                             wb_we,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic [READ_PORTS-1:0]            load_related,
  output logic                             stall_req,
  output logic [READ_PORTS-1:0]            hold_valid,
  output logic [CNT_WIDTH-1:0]             stall_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    fwd_port_mux #(
      .FWD_STAGES(FWD_STAGES),
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .ZERO_REG  (ZERO_REG)
    ) u_mux (
      .clk         (clk),
      .rst         (rst),
      .id_stall    (id_stall),
      .read_en     (read_en[p]),
      .read_addr   (read_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .reg_data    (reg_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .fwd_we      (fwd_we),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data),
      .fwd_load    (fwd_load),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .read_data   (read_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .load_related(load_related[p]),
      .hold_valid  (hold_valid[p])
    );
  end

  assign stall_req = |load_related;

  // Saturating increment: one count per stalled cycle regardless of how many ports hit.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_req && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
